accum_scheduler: RTL and testbench
==================================

Name: accum_scheduler

Overview:
- Time-multiplexed synaptic accumulation controller; replaces the fully parallel N x N adder tree with one LANES-wide gated adder, sequenced over neurons and weight chunks.
- Per timestep: latches the presynaptic spike vector, walks weight memory row by row (neuron i), accumulates spike-gated signed weights, emits one membrane-input sum per neuron over a valid/ready stream.
- Sits between the weight SRAM (1-cycle read latency) and the neuron update stage.

Parameters:
N, 256, number of neurons = number of synapses per neuron; multiple of LANES
WIDTH, 32, signed weight width
LANES, 8, weights per memory word; power of 2, >=1
OUT_WIDTH, WIDTH+$clog2(N), sum width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a timestep pass; sampled only in IDLE
spike_in  in  N  presynaptic spikes; latched on accepted start
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse after the last sum handshake
w_rd_en  out  1  weight read strobe
w_rd_addr  out  $clog2(N*N/LANES)  word address = i*(N/LANES)+c
w_rd_data  in  LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]; valid the cycle after w_rd_en
sum_valid  out  1  result valid
sum_ready  in  1  downstream accept
sum_idx  out  $clog2(N)  neuron index of sum_data
sum_data  out  OUT_WIDTH  signed accumulated sum

Behaviour:
- Reset (async, reset=0): state IDLE; busy, done, w_rd_en, sum_valid = 0; w_rd_addr, sum_idx, sum_data, acc, counters = 0; spike latch = 0.
- States: IDLE, FETCH, DRAIN, OUT, DONE.
- IDLE: start=1 -> latch spike_in, i=0, c=0, acc=0, -> FETCH. start is ignored in every other state.
- FETCH: w_rd_en=1 with addr i*(N/LANES)+c each cycle; c increments; on c=N/LANES-1 -> DRAIN.
- Accumulate every cycle following w_rd_en: acc += sum over k of (spike[c_d*LANES+k] ? sext(lane k) : 0), where c_d is c delayed one cycle. Lanes sign-extended to OUT_WIDTH; no saturation (OUT_WIDTH is overflow-free by construction).
- DRAIN: one cycle absorbing the last read data -> OUT.
- OUT: sum_valid=1, sum_idx=i, sum_data=acc; both held stable until sum_valid&&sum_ready. On handshake: i==N-1 -> DONE, else i++, c=0, acc=0 -> FETCH.
- DONE: done=1 for one cycle, busy=0 -> IDLE. Accepting start next cycle is allowed.
- Throughput: N/LANES+2 cycles per neuron with sum_ready tied high; total N*(N/LANES+2)+1 cycles from start to done.
- No reads are issued in OUT; backpressure stalls only the output.
- spike_in changes while busy have no effect.
- Reset mid-pass: immediate abort to IDLE; no partial sum emitted; any in-flight read data is discarded.

Optional Feature:
- SKIP_ZERO_CHUNK_EN defined: in FETCH, chunks whose LANES spike bits are all zero issue no read and take no cycle. The scan advances to the next nonzero chunk, with a combinational priority find over the latched spikes.
  - A neuron with an all-zero spike vector goes FETCH -> DRAIN directly and emits sum 0.
  - sum_data and sum_idx sequence are identical to the feature-off case; only cycle counts and w_rd_en count shrink.
- Undefined: every chunk is read, regardless of spikes.

Decomposition:
- Package accum_pkg: state enum (IDLE, FETCH, DRAIN, OUT, DONE), function computing OUT_WIDTH, localparams CHUNKS=N/LANES and address widths.
- Sub-module lane_sum: combinational; LANES weights + LANES spike bits -> OUT_WIDTH signed gated sum.
- Scheduler FSM, counters, read pipeline and acc stay in accum_scheduler.

Test Plan:
- N=8, LANES=4, all weights=1, spike_in=8'hFF, sum_ready=1 -> sums 8 for idx 0..7 in order; done exactly 8*(2+2)+1=33 cycles after start.
- Row 3 weights = -5, spike_in=8'h0F -> sum_idx=3 gives -20 (sign-extended, OUT_WIDTH=35); other rows per their weights.
- Weights 32'h7FFFFFFF, spikes all 1 -> sum = 8*(2^31-1) with no wrap.
- sum_ready low 10 cycles on idx 2 -> sum_valid/sum_idx/sum_data stable; zero w_rd_en during stall; then idx 3 follows normally.
- start pulsed mid-pass and spike_in toggled -> ignored, results unchanged; reset asserted during FETCH -> all outputs 0 same cycle, restart gives correct sums.
- SKIP_ZERO_CHUNK_EN, spike_in=8'h0F -> one w_rd_en per neuron, addresses 0,2,4,...; sums identical to the non-skip build.

Source files
------------

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types and sizing helpers for accum_scheduler
//
// Purpose: scheduler FSM state enum plus the functions that derive the
// chunk count, weight-address width and overflow-free sum width from the
// top-level parameters. Default sizes are provided as localparams.
package accum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // N signed terms of WIDTH bits cannot overflow WIDTH+clog2(N) bits.
  function automatic int out_width(input int width, input int n);
    return width + $clog2(n);
  endfunction

  function automatic int chunks(input int n, input int lanes);
    return n / lanes;
  endfunction

  function automatic int addr_width(input int n, input int lanes);
    return clog2_min1(n * n / lanes);
  endfunction

  localparam int DEF_N         = 256;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_LANES     = 8;
  localparam int DEF_CHUNKS    = chunks(DEF_N, DEF_LANES);
  localparam int DEF_ADDR_W    = addr_width(DEF_N, DEF_LANES);
  localparam int DEF_OUT_WIDTH = out_width(DEF_WIDTH, DEF_N);

endpackage

// File: rtl/lane_sum.sv
// rtl/lane_sum.sv - spike-gated signed sum of one weight memory word
//
// Purpose: combinational adder over LANES weights; lane k contributes its
// sign-extended weight when spikes[k] is set, otherwise zero.
// Ports:
//   w_data  in  LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]
//   spikes  in  LANES        gate bit per lane
//   sum     out OUT_WIDTH    signed gated sum
module lane_sum #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 8,
  parameter int OUT_WIDTH = 40
) (
  input  logic [LANES*WIDTH-1:0]     w_data,
  input  logic [LANES-1:0]           spikes,
  output logic signed [OUT_WIDTH-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      // Size cast of a signed operand sign-extends the lane to OUT_WIDTH.
      if (spikes[k]) sum = sum + OUT_WIDTH'($signed(w_data[k*WIDTH +: WIDTH]));
    end
  end

endmodule

// File: rtl/accum_scheduler.sv
// rtl/accum_scheduler.sv - time-multiplexed synaptic accumulation controller
//
// Purpose: per timestep, latches the spike vector, walks the weight SRAM row
// by row (one row per neuron, CHUNKS words per row), accumulates spike-gated
// weights through one LANES-wide adder and streams one sum per neuron.
// Optional build macro: SKIP_ZERO_CHUNK_EN - chunks whose spike bits are all
// zero are skipped in FETCH (no read, no cycle).
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a pass (sampled only in IDLE)
//   spike_in   in   N presynaptic spikes, latched on accepted start
//   busy       out  pass in progress
//   done       out  one-cycle pulse after the last sum handshake
//   w_rd_en    out  weight read strobe
//   w_rd_addr  out  word address i*CHUNKS+c
//   w_rd_data  in   read data, valid the cycle after w_rd_en
//   sum_valid  out  result valid
//   sum_ready  in   downstream accept
//   sum_idx    out  neuron index of sum_data
//   sum_data   out  signed accumulated sum
module accum_scheduler
  import accum_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  localparam int OUT_WIDTH = out_width(WIDTH, N),
  localparam int CHUNKS    = chunks(N, LANES),
  localparam int AW        = addr_width(N, LANES),
  localparam int IW        = clog2_min1(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           spike_in,
  output logic                   busy,
  output logic                   done,
  output logic                   w_rd_en,
  output logic [AW-1:0]          w_rd_addr,
  input  logic [LANES*WIDTH-1:0] w_rd_data,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [IW-1:0]          sum_idx,
  output logic [OUT_WIDTH-1:0]   sum_data
);

  localparam int CW = clog2_min1(CHUNKS);

  state_e                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [CW-1:0]          c_q, c_d;
  logic [CW-1:0]          cd_q, cd_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [N-1:0]           spike_q, spike_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]          w_rd_addr_q, w_rd_addr_d;
  logic                   sum_valid_q, sum_valid_d;
  logic [IW-1:0]          sum_idx_q, sum_idx_d;
  logic [OUT_WIDTH-1:0]   sum_data_q, sum_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [CHUNKS-1:0]      chunk_live;
  int                     find_from;
  logic                   find_hit;
  logic [CW-1:0]          find_idx;
  logic [LANES-1:0]       lane_spikes;
  logic signed [OUT_WIDTH-1:0] lane_total;
  logic [IW-1:0]          i_next;

  function automatic logic [AW-1:0] word_addr(input logic [IW-1:0] row,
                                              input logic [CW-1:0] chunk);
    return AW'(row) * AW'(CHUNKS) + AW'(chunk);
  endfunction

`ifdef SKIP_ZERO_CHUNK_EN
  // The first chunk of a pass is chosen in IDLE, before spikes are latched.
  logic [N-1:0] scan_spikes;
  always_comb begin
    scan_spikes = (state_q == IDLE) ? spike_in : spike_q;
    for (int k = 0; k < CHUNKS; k++) begin
      chunk_live[k] = |scan_spikes[k*LANES +: LANES];
    end
  end
`else
  assign chunk_live = '1;
`endif

  // Priority find: lowest live chunk at or after find_from. Entering FETCH
  // searches from chunk 0, inside FETCH from the chunk after the current one.
  always_comb begin
    find_from = (state_q == FETCH) ? int'(c_q) + 1 : 0;
    find_hit  = 1'b0;
    find_idx  = '0;
    for (int k = CHUNKS - 1; k >= 0; k--) begin
      if (k >= find_from && chunk_live[k]) begin
        find_hit = 1'b1;
        find_idx = CW'(k);
      end
    end
  end

  // Read data belongs to the chunk addressed one cycle earlier.
  always_comb begin
    lane_spikes = spike_q[int'(cd_q)*LANES +: LANES];
  end

  lane_sum #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_lane_sum (
    .w_data (w_rd_data),
    .spikes (lane_spikes),
    .sum    (lane_total)
  );

  assign i_next = i_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    c_d         = c_q;
    cd_d        = c_q;
    acc_d       = acc_q;
    spike_d     = spike_q;
    rd_pend_d   = w_rd_en_q;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = w_rd_addr_q;
    sum_valid_d = sum_valid_q;
    sum_idx_d   = sum_idx_q;
    sum_data_d  = sum_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (rd_pend_q) acc_d = acc_q + lane_total;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          spike_d     = spike_in;
          i_d         = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
          c_d         = find_idx;
          w_rd_en_d   = find_hit;
          w_rd_addr_d = word_addr('0, find_idx);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // A FETCH cycle without a read only happens for an all-skipped row.
        if (w_rd_en_q && find_hit) begin
          c_d         = find_idx;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = word_addr(i_q, find_idx);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // acc_d already includes the last read word.
        state_d     = OUT;
        sum_valid_d = 1'b1;
        sum_idx_d   = i_q;
        sum_data_d  = acc_d;
      end
      OUT: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          if (i_q == IW'(N - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            i_d         = i_next;
            acc_d       = '0;
            c_d         = find_idx;
            w_rd_en_d   = find_hit;
            w_rd_addr_d = word_addr(i_next, find_idx);
            state_d     = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      c_q         <= '0;
      cd_q        <= '0;
      acc_q       <= '0;
      spike_q     <= '0;
      rd_pend_q   <= 1'b0;
      w_rd_en_q   <= 1'b0;
      w_rd_addr_q <= '0;
      sum_valid_q <= 1'b0;
      sum_idx_q   <= '0;
      sum_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      c_q         <= c_d;
      cd_q        <= cd_d;
      acc_q       <= acc_d;
      spike_q     <= spike_d;
      rd_pend_q   <= rd_pend_d;
      w_rd_en_q   <= w_rd_en_d;
      w_rd_addr_q <= w_rd_addr_d;
      sum_valid_q <= sum_valid_d;
      sum_idx_q   <= sum_idx_d;
      sum_data_q  <= sum_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_rd_en   = w_rd_en_q;
  assign w_rd_addr = w_rd_addr_q;
  assign sum_valid = sum_valid_q;
  assign sum_idx   = sum_idx_q;
  assign sum_data  = sum_data_q;

endmodule

// File: tb/tb_accum_scheduler.sv
// tb/tb_accum_scheduler.sv - self-checking bench for accum_scheduler
module tb_accum_scheduler;

  localparam int N     = 8;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int CH    = N / LANES;
  localparam int OW    = 35;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [N-1:0]           spike_in = '0;
  logic                   busy, done, w_rd_en, sum_valid;
  logic [3:0]             w_rd_addr;
  logic [LANES*WIDTH-1:0] w_rd_data = '0;
  logic                   sum_ready = 1'b1;
  logic [2:0]             sum_idx;
  logic [OW-1:0]          sum_data;

  int checks = 0;
  int errors = 0;

  logic signed [WIDTH-1:0] wt [N][N];
  logic [LANES*WIDTH-1:0]  mem [N*CH];
  int                      got_idx[$];
  logic [OW-1:0]           got_data[$];
  int                      addr_log[$];
  int                      rd_cnt = 0;

  accum_scheduler #(.N(N), .WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spike_in  (spike_in),
    .busy      (busy),
    .done      (done),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .w_rd_data (w_rd_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_idx   (sum_idx),
    .sum_data  (sum_data)
  );

  always #5 clk = ~clk;

  // Weight SRAM, one-cycle read latency.
  always @(posedge clk) if (w_rd_en) w_rd_data <= mem[w_rd_addr];

  always @(negedge clk) begin
    if (reset) begin
      if (sum_valid && sum_ready) begin
        got_idx.push_back(int'(sum_idx));
        got_data.push_back(sum_data);
      end
      if (w_rd_en) begin
        rd_cnt++;
        addr_log.push_back(int'(w_rd_addr));
      end
    end
  end

  // Reference: dot product of row i with the spike vector.
  function automatic logic [OW-1:0] ref_sum(input int i, input logic [N-1:0] sp);
    longint s = 0;
    for (int j = 0; j < N; j++) if (sp[j]) s += longint'(wt[i][j]);
    return OW'(s);
  endfunction

  function automatic bit chunk_read(input int c, input logic [N-1:0] sp);
`ifdef SKIP_ZERO_CHUNK_EN
    logic [N-1:0] m;
    m = sp >> (c * LANES);
    return m[LANES-1:0] != '0;
`else
    return (c >= 0);
`endif
  endfunction

  // Per neuron: one cycle per read (one idle FETCH cycle if none), DRAIN, OUT.
  function automatic int exp_cycles(input logic [N-1:0] sp);
    int total = 1;
    for (int i = 0; i < N; i++) begin
      int nz = 0;
      for (int c = 0; c < CH; c++) if (chunk_read(c, sp)) nz++;
      total += ((nz == 0) ? 1 : nz) + 2;
    end
    return total;
  endfunction

  function automatic int exp_reads(input logic [N-1:0] sp);
    int r = 0;
    for (int c = 0; c < CH; c++) if (chunk_read(c, sp)) r += N;
    return r;
  endfunction

  task automatic load_mem();
    for (int w = 0; w < N*CH; w++) mem[w] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mem[i*CH + j/LANES][(j%LANES)*WIDTH +: WIDTH] = wt[i][j];
  endtask

  task automatic run_pass(input logic [N-1:0] sp, input bit rand_ready, output int cycles);
    @(posedge clk); #1;
    got_idx.delete(); got_data.delete(); addr_log.delete(); rd_cnt = 0;
    spike_in = sp; start = 1'b1; sum_ready = 1'b1; cycles = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sum_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin cycles = n; break; end
    end
    sum_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, w_rd_en, sum_valid, w_rd_addr, sum_idx, sum_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0",
               {busy, done, w_rd_en, sum_valid, w_rd_addr, sum_idx, sum_data});
    end
    reset = 1'b1;
  endtask

  task automatic test_all_ones();
    int cyc, k, bad;
    logic [N-1:0] sp = 8'hFF;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = 32'sd1;
    load_mem();
    run_pass(sp, 1'b0, cyc);
    checks++;
    if (cyc !== exp_cycles(sp)) begin
      errors++; $display("FAIL ones_cycles: got %0d required %0d", cyc, exp_cycles(sp));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_in_done: got %0b required 0", busy); end
    checks++;
    if (got_idx.size() != N) begin
      errors++; $display("FAIL ones_count: got %0d required %0d", got_idx.size(), N);
    end else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_idx[n] !== n || got_data[n] !== OW'(8)) begin
          errors++;
          $display("FAIL ones_sum[%0d]: got idx %0d data %0d required idx %0d data 8", n, got_idx[n], got_data[n], n);
        end
      end
    end
    k = 0; bad = 0;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < CH; c++)
        if (chunk_read(c, sp)) begin
          if (k >= addr_log.size() || addr_log[k] !== i*CH + c) bad++;
          k++;
        end
    checks++;
    if (bad != 0 || k != addr_log.size()) begin
      errors++; $display("FAIL ones_addr: got %0d reads with %0d wrong required %0d reads", addr_log.size(), bad, k);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ones_done_pulse: got done %0b busy %0b required 0 0", done, busy);
    end
  endtask

  task automatic test_neg_row();
    int cyc, k, bad;
    logic [N-1:0] sp = 8'h0F;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
      wt[i][j] = (i == 3) ? -32'sd5 : $signed(32'($urandom));
    load_mem();
    run_pass(sp, 1'b0, cyc);
    checks++;
    if (got_idx.size() != N) begin
      errors++; $display("FAIL neg_count: got %0d required %0d", got_idx.size(), N);
    end else begin
      checks++;
      if (got_data[3] !== -35'sd20) begin
        errors++; $display("FAIL neg_row3: got %0h required %0h", got_data[3], -35'sd20);
      end
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_idx[n] !== n || got_data[n] !== ref_sum(n, sp)) begin
          errors++;
          $display("FAIL neg_sum[%0d]: got idx %0d data %0h required idx %0d data %0h", n, got_idx[n], got_data[n], n, ref_sum(n, sp));
        end
      end
    end
    checks++;
    if (cyc !== exp_cycles(sp) || rd_cnt !== exp_reads(sp)) begin
      errors++; $display("FAIL neg_timing: got %0d cycles %0d reads required %0d cycles %0d reads", cyc, rd_cnt, exp_cycles(sp), exp_reads(sp));
    end
    k = 0; bad = 0;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < CH; c++)
        if (chunk_read(c, sp)) begin
          if (k >= addr_log.size() || addr_log[k] !== i*CH + c) bad++;
          k++;
        end
    checks++;
    if (bad != 0 || k != addr_log.size()) begin
      errors++; $display("FAIL neg_addr: got %0d reads with %0d wrong required %0d reads", addr_log.size(), bad, k);
    end
  endtask

  task automatic test_max();
    int cyc;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = 32'sh7FFFFFFF;
    load_mem();
    run_pass(8'hFF, 1'b0, cyc);
    checks++;
    if (got_idx.size() != N) begin
      errors++; $display("FAIL max_count: got %0d required %0d", got_idx.size(), N);
    end else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_data[n] !== OW'(64'd17179869176)) begin
          errors++; $display("FAIL max_sum[%0d]: got %0h required %0h", n, got_data[n], OW'(64'd17179869176));
        end
      end
    end
  endtask

  task automatic test_random_backpressure();
    int cyc;
    logic [N-1:0] sp;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = $signed(32'($urandom));
      load_mem();
      sp = (p == 0) ? 8'h00 : 8'($urandom);
      run_pass(sp, 1'b1, cyc);
      checks++;
      if (got_idx.size() != N || rd_cnt !== exp_reads(sp)) begin
        errors++; $display("FAIL rand%0d_count: got %0d sums %0d reads required %0d sums %0d reads", p, got_idx.size(), rd_cnt, N, exp_reads(sp));
      end else begin
        for (int n = 0; n < N; n++) begin
          checks++;
          if (got_idx[n] !== n || got_data[n] !== ref_sum(n, sp)) begin
            errors++;
            $display("FAIL rand%0d_sum[%0d]: got idx %0d data %0h required idx %0d data %0h", p, n, got_idx[n], got_data[n], n, ref_sum(n, sp));
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int cyc = 0;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    logic [N-1:0] sp = 8'($urandom) | 8'h81;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = $signed(32'($urandom));
    load_mem();
    @(posedge clk); #1;
    got_idx.delete(); got_data.delete(); addr_log.delete(); rd_cnt = 0;
    spike_in = sp; start = 1'b1;
    for (int n = 0; n < 3000 && !fin; n++) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      if (!stalled && sum_valid && sum_idx == 3'd2) begin
        sum_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1; cyc++;
          checks++;
          if (sum_valid !== 1'b1 || sum_idx !== 3'd2 || sum_data !== ref_sum(2, sp) || w_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v%0b idx %0d data %0h rd %0b required v1 idx 2 data %0h rd 0", s, sum_valid, sum_idx, sum_data, w_rd_en, ref_sum(2, sp));
          end
        end
        sum_ready = 1'b1;
        stalled = 1'b1;
      end
      if (done) fin = 1'b1;
    end
    checks++;
    if (!stalled || cyc !== exp_cycles(sp) + 10) begin
      errors++; $display("FAIL stall_cycles: got %0d stalled %0b required %0d", cyc, stalled, exp_cycles(sp) + 10);
    end
    checks++;
    if (got_idx.size() != N) begin
      errors++; $display("FAIL stall_count: got %0d required %0d", got_idx.size(), N);
    end else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_idx[n] !== n || got_data[n] !== ref_sum(n, sp)) begin
          errors++;
          $display("FAIL stall_sum[%0d]: got idx %0d data %0h required idx %0d data %0h", n, got_idx[n], got_data[n], n, ref_sum(n, sp));
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc = -1;
    logic [N-1:0] sp = 8'($urandom);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = $signed(32'($urandom));
    load_mem();
    @(posedge clk); #1;
    got_idx.delete(); got_data.delete(); addr_log.delete(); rd_cnt = 0;
    spike_in = sp; start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      spike_in = 8'($urandom);
      if (done) begin cyc = n; break; end
    end
    start = 1'b0;
    checks++;
    if (cyc !== exp_cycles(sp)) begin
      errors++; $display("FAIL ignore_cycles: got %0d required %0d", cyc, exp_cycles(sp));
    end
    checks++;
    if (got_idx.size() != N) begin
      errors++; $display("FAIL ignore_count: got %0d required %0d", got_idx.size(), N);
    end else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_idx[n] !== n || got_data[n] !== ref_sum(n, sp)) begin
          errors++;
          $display("FAIL ignore_sum[%0d]: got idx %0d data %0h required idx %0d data %0h", n, got_idx[n], got_data[n], n, ref_sum(n, sp));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [N-1:0] sp = 8'hFF;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = $signed(32'($urandom));
    load_mem();
    @(posedge clk); #1;
    got_idx.delete(); got_data.delete();
    spike_in = sp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || w_rd_en !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got busy %0b rd %0b required 1 1", busy, w_rd_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, w_rd_en, sum_valid, w_rd_addr, sum_idx, sum_data} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %0h required 0", {busy, done, w_rd_en, sum_valid, w_rd_addr, sum_idx, sum_data});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (got_idx.size() != 0) begin
      errors++; $display("FAIL abort_no_sum: got %0d sums required 0", got_idx.size());
    end
    sp = 8'($urandom);
    run_pass(sp, 1'b0, cyc);
    checks++;
    if (got_idx.size() != N || cyc !== exp_cycles(sp)) begin
      errors++; $display("FAIL restart_count: got %0d sums %0d cycles required %0d sums %0d cycles", got_idx.size(), cyc, N, exp_cycles(sp));
    end else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (got_idx[n] !== n || got_data[n] !== ref_sum(n, sp)) begin
          errors++;
          $display("FAIL restart_sum[%0d]: got idx %0d data %0h required idx %0d data %0h", n, got_idx[n], got_data[n], n, ref_sum(n, sp));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_neg_row();
    test_max();
    test_random_backpressure();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
